acs_array: RTL and testbench
============================

Name: acs_array

Overview:
- Parametrised add-compare-select array for the Viterbi decoder datapath.
- Registers one path metric per trellis state and performs one trellis step per accepted branch-metric set.
- Uses modulo (wrap-around) subtract-and-sign comparison, so metrics never need normalisation.
- Emits per-state survivor decision bits and the best state to the traceback unit.

Parameters:
- K, 3, constraint length; N = 2^(K-1) states.
- G0, 7 (octal), generator polynomial for coded bit c0; bit K-1 taps the input bit.
- G1, 5 (octal), generator polynomial for coded bit c1.
- BM_W, 2, branch metric width.
- PM_W, 6, path metric width; must satisfy max metric spread < 2^(PM_W-1).
- INIT_BIAS, 16, initial metric of every nonzero state at reset/sof.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  branch metric set valid; one trellis step per cycle it is high
- sof  input  1  start of frame; qualified by in_valid
- bm  input  4*BM_W  branch metrics; slice idx = {c0,c1} (idx 0 = "00" ... idx 3 = "11")
- out_valid  output  1  decision/best_state valid
- decision  output  N  bit s = 1 if state s selected predecessor p1
- best_state  output  K-1  index of minimum new metric
- pm_flat  output  N*PM_W  registered path metrics, state 0 in LSBs (debug/verification)

Behaviour:
- Reset (rst high at a clk edge), all outputs registered:
  - pm[0] = 0; pm[s≠0] = INIT_BIAS.
  - out_valid = 0, decision = 0, best_state = 0.
- Trellis, for next state s:
  - predecessors p0 = (2s) mod N, p1 = (2s+1) mod N.
  - input bit u = s[K-2].
  - shift register r = {u, p} (K bits, u = MSB).
  - cj = parity(r & Gj).
- ACS per state:
  - cand0 = old[p0] + bm[{c0,c1} of p0]; cand1 = old[p1] + bm[{c0,c1} of p1].
  - All additions are modulo 2^PM_W.
  - cand1 < cand0 iff MSB of (cand1 - cand0) mod 2^PM_W is 1.
  - Select cand1 (decision 1) only if strictly less; ties select p0 (decision 0).
- old metrics: the pm registers, or the reset vector {0, INIT_BIAS, ...} when sof & in_valid. sof reinitialises and applies the step in the same cycle.
- Latency 1:
  - in_valid at edge t updates pm, decision and best_state at edge t.
  - out_valid is high for exactly that following cycle.
- in_valid low: pm, decision and best_state hold; out_valid = 0. sof is ignored when in_valid is low.
- best_state:
  - modulo-compare reduction over the new metrics, using the same MSB rule.
  - ties resolve to the lower index.
  - registered with decision.
- rst has priority over in_valid/sof in the same cycle.
- No backpressure; the downstream traceback must accept one decision vector per out_valid.

Decomposition:
- Package viterbi_pkg holds:
  - localparam N derivation;
  - function parity;
  - function exp_sym(p, u) returning {c0,c1};
  - function mod_lt(a, b) implementing the sign-of-difference compare.
- Sub-module acs_cell (one state: two adders, mod_lt, mux, decision bit), instantiated N times by generate.
- The best_state reduction tree stays in acs_array.

Test Plan:
- Reset: assert rst 1 cycle -> pm_flat = {16,16,16,0} (state3..0), out_valid 0, decision 0, best_state 0.
- Step from init: sof=1, in_valid=1, bm = {2,1,1,0} (idx3..0) -> next cycle pm = {17,2,17,0} (state3..0), decision = 0000, best_state 0, out_valid 1 for one cycle.
- Tie rule: same step as above -> states 1 and 3 tie at 17; decision bits 1 and 3 must be 0.
- Wrap-around: 200 random noisy symbols with PM_W=6 -> decision and best_state match a reference model using unbounded integers, despite pm wrapping past 63.
- Hold/gaps: in_valid deasserted for 5 cycles mid-stream -> pm_flat unchanged, out_valid 0, resumes correctly.
- Mid-frame sof and mid-frame rst:
  - sof mid-frame -> metrics equal the sof-from-init result.
  - rst asserted together with in_valid -> reset vector, out_valid 0.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Package for the Viterbi add-compare-select datapath.
// Holds the default code parameters, the state-count derivation and the
// helper functions shared by the ACS array and its cells:
//   num_states - number of trellis states for a constraint length
//   parity     - XOR reduction of a tap-masked shift register
//   exp_sym    - expected coded symbol {c0,c1} leaving predecessor p on input u
//   mod_lt     - wrap-around "a < b" via the sign bit of (a - b) mod 2^w
package viterbi_pkg;

  localparam int K_DEFAULT = 3;
  localparam int G0_DEFAULT = 'o7;
  localparam int G1_DEFAULT = 'o5;

  function automatic int num_states(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

  // The input bit u sits in the MSB of the K-bit shift register, the
  // predecessor state fills the lower K-1 bits.
  function automatic logic [1:0] exp_sym(input int p, input int u, input int k,
                                         input int g0, input int g1);
    logic [31:0] r;
    r = 32'((u << (k - 1)) | p);
    return {parity(r & 32'(g0)), parity(r & 32'(g1))};
  endfunction

  // Valid as long as the true spread between a and b is below 2^(w-1).
  function automatic logic mod_lt(input logic [31:0] a, input logic [31:0] b,
                                  input int w);
    return (((a - b) >> (w - 1)) & 32'd1) != 32'd0;
  endfunction

endpackage

// File: rtl/acs_array_if.sv
// Interface bundling the branch-metric input stream and the decision output
// stream of the ACS array.
//   master: drives in_valid/sof/bm, observes the results (source/traceback side)
//   slave : the ACS array itself
interface acs_array_if #(
  parameter int K    = 3,
  parameter int BM_W = 2,
  parameter int PM_W = 6
);
  localparam int N = 1 << (K - 1);

  logic                 in_valid;
  logic                 sof;
  logic [4*BM_W-1:0]    bm;
  logic                 out_valid;
  logic [N-1:0]         decision;
  logic [K-2:0]         best_state;
  logic [N*PM_W-1:0]    pm_flat;

  modport master (
    output in_valid, sof, bm,
    input  out_valid, decision, best_state, pm_flat
  );

  modport slave (
    input  in_valid, sof, bm,
    output out_valid, decision, best_state, pm_flat
  );

endinterface

// File: rtl/acs_array_cell.sv
// Single-state add-compare-select cell.
//   old0/old1 : path metrics of predecessors p0/p1
//   bm0/bm1   : branch metrics of the p0->s and p1->s transitions
//   new_pm    : surviving metric (modulo 2^PM_W)
//   dec       : 1 when p1 survives; ties favour p0
module acs_cell
  import viterbi_pkg::*;
#(
  parameter int BM_W = 2,
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] old0,
  input  logic [PM_W-1:0] old1,
  input  logic [BM_W-1:0] bm0,
  input  logic [BM_W-1:0] bm1,
  output logic [PM_W-1:0] new_pm,
  output logic            dec
);

  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  always_comb begin
    cand0  = old0 + PM_W'(bm0);
    cand1  = old1 + PM_W'(bm1);
    // Strictly-less test, so an exact tie keeps the p0 candidate.
    dec    = mod_lt(32'(cand1), 32'(cand0), PM_W);
    new_pm = dec ? cand1 : cand0;
  end

endmodule

// File: rtl/acs_array.sv
// Add-compare-select array of a Viterbi decoder.
// One path metric register per trellis state; each accepted branch-metric
// set advances the trellis by one step. Metrics wrap modulo 2^PM_W and are
// compared by sign of difference, so no normalisation is needed.
//   clk, rst          : clock, synchronous active-high reset
//   bus.in_valid/sof  : step strobe / frame restart (sof only with in_valid)
//   bus.bm            : four branch metrics, slice index {c0,c1}
//   bus.out_valid     : one-cycle strobe for each completed step
//   bus.decision      : survivor bits, bit s = 1 when p1 survived
//   bus.best_state    : lowest-metric state (lowest index on ties)
//   bus.pm_flat       : registered path metrics, state 0 in the LSBs
module acs_array
  import viterbi_pkg::*;
#(
  parameter int K         = K_DEFAULT,
  parameter int G0        = G0_DEFAULT,
  parameter int G1        = G1_DEFAULT,
  parameter int BM_W      = 2,
  parameter int PM_W      = 6,
  parameter int INIT_BIAS = 16
) (
  input logic        clk,
  input logic        rst,
  acs_array_if.slave bus
);

  localparam int N = num_states(K);

  logic [PM_W-1:0] pm_q   [N];
  logic [PM_W-1:0] old_pm [N];
  logic [PM_W-1:0] new_pm [N];
  logic [N-1:0]    dec_w;
  logic [K-2:0]    best_w;
  logic            out_valid_q;
  logic [N-1:0]    decision_q;
  logic [K-2:0]    best_q;

  // A frame start replaces the stored metrics by the start vector before
  // the step, so the first step of a frame needs no extra cycle.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (bus.sof && bus.in_valid)
        old_pm[i] = (i == 0) ? '0 : PM_W'(INIT_BIAS);
      else
        old_pm[i] = pm_q[i];
    end
  end

  // Connectivity is fixed at elaboration: predecessors and the symbol each
  // branch expects are constants per state.
  for (genvar s = 0; s < N; s++) begin : g_cell
    localparam int P0 = (2 * s) % N;
    localparam int P1 = (2 * s + 1) % N;
    localparam int U  = (s >> (K - 2)) & 1;
    localparam logic [1:0] SYM0 = exp_sym(P0, U, K, G0, G1);
    localparam logic [1:0] SYM1 = exp_sym(P1, U, K, G0, G1);

    acs_cell #(
      .BM_W (BM_W),
      .PM_W (PM_W)
    ) u_cell (
      .old0   (old_pm[P0]),
      .old1   (old_pm[P1]),
      .bm0    (bus.bm[int'(SYM0)*BM_W +: BM_W]),
      .bm1    (bus.bm[int'(SYM1)*BM_W +: BM_W]),
      .new_pm (new_pm[s]),
      .dec    (dec_w[s])
    );

    assign bus.pm_flat[s*PM_W +: PM_W] = pm_q[s];
  end

  // Minimum search over the new metrics; strict less keeps the lower index
  // on ties.
  always_comb begin
    best_w = '0;
    for (int i = 1; i < N; i++) begin
      if (mod_lt(32'(new_pm[i]), 32'(new_pm[best_w]), PM_W))
        best_w = (K - 1)'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        pm_q[i] <= (i == 0) ? '0 : PM_W'(INIT_BIAS);
      out_valid_q <= 1'b0;
      decision_q  <= '0;
      best_q      <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        for (int i = 0; i < N; i++)
          pm_q[i] <= new_pm[i];
        decision_q <= dec_w;
        best_q     <= best_w;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.decision   = decision_q;
  assign bus.best_state = best_q;

endmodule

// File: tb/tb_acs_array.sv
// Self-checking bench for acs_array (K=3, G0=7, G1=5, BM_W=2, PM_W=6).
// Hand-computed trellis vectors plus a random stream checked against an
// unbounded-integer reference model through a scoreboard queue.
module tb_acs_array;

  localparam int K    = 3;
  localparam int N    = 4;
  localparam int BM_W = 2;
  localparam int PM_W = 6;

  typedef struct {
    logic           sof;
    int             b[4];
    int             epm[4];
    logic [N-1:0]   edec;
    int             ebest;
  } vec_t;

  typedef struct {
    logic [N-1:0]      dec;
    logic [K-2:0]      best;
    logic [N*PM_W-1:0] pm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  acs_array_if #(.K(K), .BM_W(BM_W), .PM_W(PM_W)) bus ();

  acs_array #(
    .K         (K),
    .G0        ('o7),
    .G1        ('o5),
    .BM_W      (BM_W),
    .PM_W      (PM_W),
    .INIT_BIAS (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   mpm[4];
  exp_t last_exp;

  localparam logic [N*PM_W-1:0] RESET_PM = {6'd16, 6'd16, 6'd16, 6'd0};

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [N*PM_W-1:0] pack_pm(input int v[4]);
    logic [N*PM_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*PM_W +: PM_W] = PM_W'(v[i]);
    return r;
  endfunction

  // Reference trellis step on unbounded integers.
  task automatic modelStep(input logic sof, input int b[4], output exp_t e);
    int old[4];
    int nw[4];
    int cand[2];
    int u, p, r, c0, c1, best;
    for (int i = 0; i < N; i++) old[i] = sof ? ((i == 0) ? 0 : 16) : mpm[i];
    e.dec = '0;
    for (int s = 0; s < N; s++) begin
      u = (s >> (K - 2)) & 1;
      for (int br = 0; br < 2; br++) begin
        p = (2 * s + br) % N;
        r = (u << (K - 1)) | p;
        c0 = $countones(r & 'o7) % 2;
        c1 = $countones(r & 'o5) % 2;
        cand[br] = old[p] + b[c0 * 2 + c1];
      end
      if (cand[1] < cand[0]) begin
        nw[s] = cand[1];
        e.dec[s] = 1'b1;
      end else begin
        nw[s] = cand[0];
      end
    end
    best = 0;
    for (int s = 1; s < N; s++) if (nw[s] < nw[best]) best = s;
    e.best = (K - 1)'(best);
    e.pm = pack_pm(nw);
    mpm = nw;
  endtask

  task automatic modelReset();
    mpm = '{0, 16, 16, 16};
  endtask

  task automatic applyStimulus(input logic sof, input int b[4]);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sof      = sof;
    for (int i = 0; i < 4; i++) bus.bm[i*BM_W +: BM_W] = BM_W'(b[i]);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.sof      = 1'b1;
  endtask

  // Output monitor: every out_valid retires one scoreboard entry.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("decision", 64'(bus.decision), 64'(e.dec));
        checkOutput("best_state", 64'(bus.best_state), 64'(e.best));
        checkOutput("pm_flat", 64'(bus.pm_flat), 64'(e.pm));
      end
    end
  end

  vec_t vecs[4];

  initial begin
    exp_t e;
    int   b[4];
    int   wait_cnt;

    // Step from init, then two ordinary steps, then a mid-frame sof that
    // must reproduce the first result.
    vecs[0] = '{sof: 1'b1, b: '{0, 1, 1, 2}, epm: '{0, 17, 2, 17}, edec: 4'b0000, ebest: 0};
    vecs[1] = '{sof: 1'b0, b: '{2, 1, 1, 0}, epm: '{2, 3, 0, 3},   edec: 4'b0000, ebest: 2};
    vecs[2] = '{sof: 1'b0, b: '{2, 0, 2, 0}, epm: '{3, 2, 2, 0},   edec: 4'b0001, ebest: 3};
    vecs[3] = '{sof: 1'b1, b: '{0, 1, 1, 2}, epm: '{0, 17, 2, 17}, edec: 4'b0000, ebest: 0};

    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
    bus.bm       = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_pm", 64'(bus.pm_flat), 64'(RESET_PM));
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_decision", 64'(bus.decision), 64'd0);
    checkOutput("reset_best", 64'(bus.best_state), 64'd0);
    rst = 1'b0;
    modelReset();

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].sof, vecs[v].b);
      e.dec  = vecs[v].edec;
      e.best = (K - 1)'(vecs[v].ebest);
      e.pm   = pack_pm(vecs[v].epm);
      sb.push_back(e);
      modelStep(vecs[v].sof, vecs[v].b, last_exp);
    end

    // Random stream long enough for the metrics to wrap many times, with a
    // gap and a further frame restart inside it.
    for (int i = 0; i < 200; i++) begin
      if (i == 100) begin
        idleCycle();
        for (int g = 0; g < 5; g++) begin
          idleCycle();
          checkOutput("gap_out_valid", 64'(bus.out_valid), 64'd0);
          checkOutput("gap_pm_hold", 64'(bus.pm_flat), 64'(last_exp.pm));
        end
      end
      for (int j = 0; j < 4; j++) b[j] = int'($urandom_range(0, 3));
      applyStimulus(i == 150, b);
      modelStep(i == 150, b, e);
      sb.push_back(e);
      last_exp = e;
    end

    // Reset wins over a simultaneous step.
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.sof      = 1'b0;
    bus.bm       = 8'hE4;
    @(negedge clk);
    checkOutput("rst_pri_pm", 64'(bus.pm_flat), 64'(RESET_PM));
    checkOutput("rst_pri_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_pri_decision", 64'(bus.decision), 64'd0);
    checkOutput("rst_pri_best", 64'(bus.best_state), 64'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    modelReset();

    // Step without sof directly after reset uses the reset metrics.
    applyStimulus(1'b0, vecs[0].b);
    modelStep(1'b0, vecs[0].b, e);
    sb.push_back(e);
    idleCycle();

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
